// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock, single state register, one block in flight.
// Round keys come precomputed on a packed bus (key i at all_keys[128*i +: 128]).

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = 8'h00;
    case (a_i)
      8'h00: y_o = 8'h52; 8'h01: y_o = 8'h09; 8'h02: y_o = 8'h6a; 8'h03: y_o = 8'hd5; 8'h04: y_o = 8'h30; 8'h05: y_o = 8'h36; 8'h06: y_o = 8'ha5; 8'h07: y_o = 8'h38;
      8'h08: y_o = 8'hbf; 8'h09: y_o = 8'h40; 8'h0a: y_o = 8'ha3; 8'h0b: y_o = 8'h9e; 8'h0c: y_o = 8'h81; 8'h0d: y_o = 8'hf3; 8'h0e: y_o = 8'hd7; 8'h0f: y_o = 8'hfb;
      8'h10: y_o = 8'h7c; 8'h11: y_o = 8'he3; 8'h12: y_o = 8'h39; 8'h13: y_o = 8'h82; 8'h14: y_o = 8'h9b; 8'h15: y_o = 8'h2f; 8'h16: y_o = 8'hff; 8'h17: y_o = 8'h87;
      8'h18: y_o = 8'h34; 8'h19: y_o = 8'h8e; 8'h1a: y_o = 8'h43; 8'h1b: y_o = 8'h44; 8'h1c: y_o = 8'hc4; 8'h1d: y_o = 8'hde; 8'h1e: y_o = 8'he9; 8'h1f: y_o = 8'hcb;
      8'h20: y_o = 8'h54; 8'h21: y_o = 8'h7b; 8'h22: y_o = 8'h94; 8'h23: y_o = 8'h32; 8'h24: y_o = 8'ha6; 8'h25: y_o = 8'hc2; 8'h26: y_o = 8'h23; 8'h27: y_o = 8'h3d;
      8'h28: y_o = 8'hee; 8'h29: y_o = 8'h4c; 8'h2a: y_o = 8'h95; 8'h2b: y_o = 8'h0b; 8'h2c: y_o = 8'h42; 8'h2d: y_o = 8'hfa; 8'h2e: y_o = 8'hc3; 8'h2f: y_o = 8'h4e;
      8'h30: y_o = 8'h08; 8'h31: y_o = 8'h2e; 8'h32: y_o = 8'ha1; 8'h33: y_o = 8'h66; 8'h34: y_o = 8'h28; 8'h35: y_o = 8'hd9; 8'h36: y_o = 8'h24; 8'h37: y_o = 8'hb2;
      8'h38: y_o = 8'h76; 8'h39: y_o = 8'h5b; 8'h3a: y_o = 8'ha2; 8'h3b: y_o = 8'h49; 8'h3c: y_o = 8'h6d; 8'h3d: y_o = 8'h8b; 8'h3e: y_o = 8'hd1; 8'h3f: y_o = 8'h25;
      8'h40: y_o = 8'h72; 8'h41: y_o = 8'hf8; 8'h42: y_o = 8'hf6; 8'h43: y_o = 8'h64; 8'h44: y_o = 8'h86; 8'h45: y_o = 8'h68; 8'h46: y_o = 8'h98; 8'h47: y_o = 8'h16;
      8'h48: y_o = 8'hd4; 8'h49: y_o = 8'ha4; 8'h4a: y_o = 8'h5c; 8'h4b: y_o = 8'hcc; 8'h4c: y_o = 8'h5d; 8'h4d: y_o = 8'h65; 8'h4e: y_o = 8'hb6; 8'h4f: y_o = 8'h92;
      8'h50: y_o = 8'h6c; 8'h51: y_o = 8'h70; 8'h52: y_o = 8'h48; 8'h53: y_o = 8'h50; 8'h54: y_o = 8'hfd; 8'h55: y_o = 8'hed; 8'h56: y_o = 8'hb9; 8'h57: y_o = 8'hda;
      8'h58: y_o = 8'h5e; 8'h59: y_o = 8'h15; 8'h5a: y_o = 8'h46; 8'h5b: y_o = 8'h57; 8'h5c: y_o = 8'ha7; 8'h5d: y_o = 8'h8d; 8'h5e: y_o = 8'h9d; 8'h5f: y_o = 8'h84;
      8'h60: y_o = 8'h90; 8'h61: y_o = 8'hd8; 8'h62: y_o = 8'hab; 8'h63: y_o = 8'h00; 8'h64: y_o = 8'h8c; 8'h65: y_o = 8'hbc; 8'h66: y_o = 8'hd3; 8'h67: y_o = 8'h0a;
      8'h68: y_o = 8'hf7; 8'h69: y_o = 8'he4; 8'h6a: y_o = 8'h58; 8'h6b: y_o = 8'h05; 8'h6c: y_o = 8'hb8; 8'h6d: y_o = 8'hb3; 8'h6e: y_o = 8'h45; 8'h6f: y_o = 8'h06;
      8'h70: y_o = 8'hd0; 8'h71: y_o = 8'h2c; 8'h72: y_o = 8'h1e; 8'h73: y_o = 8'h8f; 8'h74: y_o = 8'hca; 8'h75: y_o = 8'h3f; 8'h76: y_o = 8'h0f; 8'h77: y_o = 8'h02;
      8'h78: y_o = 8'hc1; 8'h79: y_o = 8'haf; 8'h7a: y_o = 8'hbd; 8'h7b: y_o = 8'h03; 8'h7c: y_o = 8'h01; 8'h7d: y_o = 8'h13; 8'h7e: y_o = 8'h8a; 8'h7f: y_o = 8'h6b;
      8'h80: y_o = 8'h3a; 8'h81: y_o = 8'h91; 8'h82: y_o = 8'h11; 8'h83: y_o = 8'h41; 8'h84: y_o = 8'h4f; 8'h85: y_o = 8'h67; 8'h86: y_o = 8'hdc; 8'h87: y_o = 8'hea;
      8'h88: y_o = 8'h97; 8'h89: y_o = 8'hf2; 8'h8a: y_o = 8'hcf; 8'h8b: y_o = 8'hce; 8'h8c: y_o = 8'hf0; 8'h8d: y_o = 8'hb4; 8'h8e: y_o = 8'he6; 8'h8f: y_o = 8'h73;
      8'h90: y_o = 8'h96; 8'h91: y_o = 8'hac; 8'h92: y_o = 8'h74; 8'h93: y_o = 8'h22; 8'h94: y_o = 8'he7; 8'h95: y_o = 8'had; 8'h96: y_o = 8'h35; 8'h97: y_o = 8'h85;
      8'h98: y_o = 8'he2; 8'h99: y_o = 8'hf9; 8'h9a: y_o = 8'h37; 8'h9b: y_o = 8'he8; 8'h9c: y_o = 8'h1c; 8'h9d: y_o = 8'h75; 8'h9e: y_o = 8'hdf; 8'h9f: y_o = 8'h6e;
      8'ha0: y_o = 8'h47; 8'ha1: y_o = 8'hf1; 8'ha2: y_o = 8'h1a; 8'ha3: y_o = 8'h71; 8'ha4: y_o = 8'h1d; 8'ha5: y_o = 8'h29; 8'ha6: y_o = 8'hc5; 8'ha7: y_o = 8'h89;
      8'ha8: y_o = 8'h6f; 8'ha9: y_o = 8'hb7; 8'haa: y_o = 8'h62; 8'hab: y_o = 8'h0e; 8'hac: y_o = 8'haa; 8'had: y_o = 8'h18; 8'hae: y_o = 8'hbe; 8'haf: y_o = 8'h1b;
      8'hb0: y_o = 8'hfc; 8'hb1: y_o = 8'h56; 8'hb2: y_o = 8'h3e; 8'hb3: y_o = 8'h4b; 8'hb4: y_o = 8'hc6; 8'hb5: y_o = 8'hd2; 8'hb6: y_o = 8'h79; 8'hb7: y_o = 8'h20;
      8'hb8: y_o = 8'h9a; 8'hb9: y_o = 8'hdb; 8'hba: y_o = 8'hc0; 8'hbb: y_o = 8'hfe; 8'hbc: y_o = 8'h78; 8'hbd: y_o = 8'hcd; 8'hbe: y_o = 8'h5a; 8'hbf: y_o = 8'hf4;
      8'hc0: y_o = 8'h1f; 8'hc1: y_o = 8'hdd; 8'hc2: y_o = 8'ha8; 8'hc3: y_o = 8'h33; 8'hc4: y_o = 8'h88; 8'hc5: y_o = 8'h07; 8'hc6: y_o = 8'hc7; 8'hc7: y_o = 8'h31;
      8'hc8: y_o = 8'hb1; 8'hc9: y_o = 8'h12; 8'hca: y_o = 8'h10; 8'hcb: y_o = 8'h59; 8'hcc: y_o = 8'h27; 8'hcd: y_o = 8'h80; 8'hce: y_o = 8'hec; 8'hcf: y_o = 8'h5f;
      8'hd0: y_o = 8'h60; 8'hd1: y_o = 8'h51; 8'hd2: y_o = 8'h7f; 8'hd3: y_o = 8'ha9; 8'hd4: y_o = 8'h19; 8'hd5: y_o = 8'hb5; 8'hd6: y_o = 8'h4a; 8'hd7: y_o = 8'h0d;
      8'hd8: y_o = 8'h2d; 8'hd9: y_o = 8'he5; 8'hda: y_o = 8'h7a; 8'hdb: y_o = 8'h9f; 8'hdc: y_o = 8'h93; 8'hdd: y_o = 8'hc9; 8'hde: y_o = 8'h9c; 8'hdf: y_o = 8'hef;
      8'he0: y_o = 8'ha0; 8'he1: y_o = 8'he0; 8'he2: y_o = 8'h3b; 8'he3: y_o = 8'h4d; 8'he4: y_o = 8'hae; 8'he5: y_o = 8'h2a; 8'he6: y_o = 8'hf5; 8'he7: y_o = 8'hb0;
      8'he8: y_o = 8'hc8; 8'he9: y_o = 8'heb; 8'hea: y_o = 8'hbb; 8'heb: y_o = 8'h3c; 8'hec: y_o = 8'h83; 8'hed: y_o = 8'h53; 8'hee: y_o = 8'h99; 8'hef: y_o = 8'h61;
      8'hf0: y_o = 8'h17; 8'hf1: y_o = 8'h2b; 8'hf2: y_o = 8'h04; 8'hf3: y_o = 8'h7e; 8'hf4: y_o = 8'hba; 8'hf5: y_o = 8'h77; 8'hf6: y_o = 8'hd6; 8'hf7: y_o = 8'h26;
      8'hf8: y_o = 8'he1; 8'hf9: y_o = 8'h69; 8'hfa: y_o = 8'h14; 8'hfb: y_o = 8'h63; 8'hfc: y_o = 8'h55; 8'hfd: y_o = 8'h21; 8'hfe: y_o = 8'h0c; 8'hff: y_o = 8'h7d;
      default: y_o = 8'h00;
    endcase
  end
endmodule

module aes_inv_mixcol (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a [4], x2 [4], x4 [4], x8 [4];
  logic [7:0] m9 [4], mb [4], md [4], me [4];

  // Constant multiplies built from doubling chains: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2
  for (genvar k = 0; k < 4; k++) begin : g_row
    assign a[k]  = col_i[31-8*k -: 8];
    assign x2[k] = xt(a[k]);
    assign x4[k] = xt(x2[k]);
    assign x8[k] = xt(x4[k]);
    assign m9[k] = x8[k] ^ a[k];
    assign mb[k] = x8[k] ^ x2[k] ^ a[k];
    assign md[k] = x8[k] ^ x4[k] ^ a[k];
    assign me[k] = x8[k] ^ x4[k] ^ x2[k];
  end

  assign col_o = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                  m9[0] ^ me[1] ^ mb[2] ^ md[3],
                  md[0] ^ m9[1] ^ me[2] ^ mb[3],
                  mb[0] ^ md[1] ^ m9[2] ^ me[3]};
endmodule

module aes_decrypt_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          ciphertext,
  input  logic [(Nr+1)*128-1:0] all_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          plaintext,
  output logic                  busy
);
  localparam int RW = $clog2(Nr + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_OUT} state_e;

  state_e          state_q;
  logic [RW-1:0]   round_q;
  logic [127:0]    st_q, plaintext_q;
  logic            out_valid_q, in_ready_q, busy_q;

  logic [127:0]    sb, rk, t, st_d;

  // InvShiftRows folded into the S-box wiring: row r of column c reads column (c-r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_byte
      localparam int DST = 4*c + r;
      localparam int SRC = 4*((c + 4 - r) % 4) + r;
      aes_inv_sbox u_sbox (.a_i(st_q[127-8*SRC -: 8]), .y_o(sb[127-8*DST -: 8]));
    end
    aes_inv_mixcol u_mix (.col_i(t[127-32*c -: 32]), .col_o(st_d[127-32*c -: 32]));
  end

  always_comb begin
    rk = '0;
    for (int i = 0; i < Nr; i++)
      if (round_q == RW'(i)) rk = all_keys[128*i +: 128];
  end

  assign t = sb ^ rk;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      st_q        <= '0;
      plaintext_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          st_q       <= ciphertext ^ all_keys[128*Nr +: 128];
          round_q    <= RW'(Nr - 1);
          state_q    <= S_ROUND;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        S_ROUND: if (round_q == '0) begin
          // Final round skips InvMixColumns
          plaintext_q <= t;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end else begin
          st_q    <= st_d;
          round_q <= round_q - 1'b1;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = plaintext_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors plus random blocks checked against a byte-level AES model.
// S-box derived from GF(2^8) inversion and the affine map.

module tb_aes_decrypt_iter;
  logic clk = 1'b0;
  logic reset, in_valid, in_valid14, out_ready;
  logic [127:0] ciphertext;
  logic [11*128-1:0] keys10;
  logic [15*128-1:0] keys14;
  logic in_ready, out_valid, busy, in_ready14, out_valid14, busy14;
  logic [127:0] plaintext, plaintext14;

  int total = 0;
  int bad = 0;

  bit [7:0] sbox [256];
  bit [7:0] isbox [256];
  bit [15*128-1:0] rkf10, rkf14;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.Nk(4), .Nr(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .all_keys(keys10), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy));

  aes_decrypt_iter #(.Nk(8), .Nr(14)) dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid14), .in_ready(in_ready14),
    .ciphertext(ciphertext), .all_keys(keys14), .out_valid(out_valid14),
    .out_ready(out_ready), .plaintext(plaintext14), .busy(busy14));

  // ---------------- reference model ----------------
  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p = 8'h00;
    bit [7:0] x = a;
    bit [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl8(input bit [7:0] b, input int k);
    bit [15:0] d = {b, b};
    return d[15-k -: 8];
  endfunction

  task automatic build_tables;
    for (int x = 0; x < 256; x++) begin
      bit [7:0] inv, s;
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic bit [7:0] gb(input bit [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic bit [127:0] sub_bytes(input bit [127:0] v, input bit inv);
    bit [127:0] res;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = inv ? isbox[gb(v, i)] : sbox[gb(v, i)];
    return res;
  endfunction

  function automatic bit [127:0] shift_rows(input bit [127:0] v, input bit inv);
    bit [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = gb(v, inv ? 4*((c - r + 4) % 4) + r : 4*((c + r) % 4) + r);
    return res;
  endfunction

  function automatic bit [127:0] mix_cols(input bit [127:0] v, input bit inv);
    bit [127:0] res;
    bit [7:0] cf [4];
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        bit [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(cf[(k - r + 4) % 4], gb(v, 4*c + k));
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic bit [15*128-1:0] expand(input bit [255:0] key, input int nk, input int nr);
    bit [31:0] w [60];
    bit [31:0] t;
    bit [7:0] rc = 8'h01;
    bit [15*128-1:0] res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) res[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return res;
  endfunction

  function automatic bit [127:0] encrypt(input bit [127:0] pt, input bit [15*128-1:0] ks, input int nr);
    bit [127:0] s = pt ^ ks[127:0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (rnd < nr) s = mix_cols(s, 1'b0);
      s ^= ks[128*rnd +: 128];
    end
    return s;
  endfunction

  function automatic bit [127:0] decrypt(input bit [127:0] ct, input bit [15*128-1:0] ks, input int nr);
    bit [127:0] s = ct ^ ks[128*nr +: 128];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[128*rnd +: 128];
      if (rnd > 0) s = mix_cols(s, 1'b1);
    end
    return s;
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge with the target DUT idle; returns at the negedge where out_valid is seen
  // (or after 40 edges), with lat = rising edges counted after the accepting edge.
  task automatic run_block(input bit use14, input logic [127:0] ct, output logic [127:0] pt, output int lat);
    ciphertext = ct;
    if (use14) in_valid14 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    in_valid14 = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (lat < 40 && (use14 ? out_valid14 : out_valid) !== 1'b1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    pt = use14 ? plaintext14 : plaintext;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (plaintext !== 128'h0) begin bad++; $display("FAIL reset_plaintext got %h want 0", plaintext); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready14 !== 1'b1 || out_valid14 !== 1'b0 || busy14 !== 1'b0) begin
      bad++; $display("FAIL reset_dut14 got rdy=%b ov=%b busy=%b want 1/0/0", in_ready14, out_valid14, busy14);
    end
  endtask

  task automatic test_fips128;
    logic [127:0] got;
    int lat;
    rkf10 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    keys10 = rkf10[11*128-1:0];
    out_ready = 1'b1;
    run_block(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, got, lat);
    total++; if (got !== 128'h00112233445566778899aabbccddeeff) begin bad++; $display("FAIL fips128_pt got %h want 00112233445566778899aabbccddeeff", got); end
    total++; if (lat != 10) begin bad++; $display("FAIL fips128_latency got %0d want 10", lat); end
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fips128_out_state got rdy=%b busy=%b want 0/1", in_ready, busy); end
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL fips128_after_hs got rdy=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_nr14;
    logic [127:0] got;
    int lat;
    rkf14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    keys14 = rkf14;
    out_ready = 1'b1;
    run_block(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089, got, lat);
    total++; if (got !== 128'h00112233445566778899aabbccddeeff) begin bad++; $display("FAIL nr14_pt got %h want 00112233445566778899aabbccddeeff", got); end
    total++; if (lat != 14) begin bad++; $display("FAIL nr14_latency got %0d want 14", lat); end
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready14 !== 1'b1 || out_valid14 !== 1'b0) begin bad++; $display("FAIL nr14_after_hs got rdy=%b ov=%b want 1/0", in_ready14, out_valid14); end
  endtask

  task automatic test_backpressure;
    logic [127:0] pt0, got;
    int lat;
    pt0 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    run_block(1'b0, encrypt(pt0, rkf10, 10), got, lat);
    total++; if (lat != 10) begin bad++; $display("FAIL bp_latency got %0d want 10", lat); end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || plaintext !== pt0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got ov=%b pt=%h rdy=%b busy=%b want 1/%h/0/1", i, out_valid, plaintext, in_ready, busy, pt0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b rdy=%b want 0/1", out_valid, in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_ghost got busy=%b ov=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] ct, got;
    int lat;
    bit seen;
    ct = {$urandom, $urandom, $urandom, $urandom};
    ciphertext = ct;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_after_reset got ov=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmid_abandoned got out_valid=1 want 0"); end
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_block(1'b0, ct, got, lat);
    total++; if (got !== decrypt(ct, rkf10, 10)) begin bad++; $display("FAIL rmid_next_pt got %h want %h", got, decrypt(ct, rkf10, 10)); end
    total++; if (lat != 10) begin bad++; $display("FAIL rmid_next_latency got %0d want 10", lat); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [127:0] pt0, got;
    int lat;
    rkf10 = expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10);
    keys10 = rkf10[11*128-1:0];
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      pt0 = {$urandom, $urandom, $urandom, $urandom};
      run_block(1'b0, encrypt(pt0, rkf10, 10), got, lat);
      total++; if (got !== pt0) begin bad++; $display("FAIL b2b_roundtrip blk=%0d got %h want %h", b, got, pt0); end
      total++; if (lat != 10) begin bad++; $display("FAIL b2b_latency blk=%0d got %0d want 10", b, lat); end
      @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_ready blk=%0d got rdy=%b ov=%b want 1/0", b, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset_release;
    logic [127:0] ct, got;
    int lat;
    ct = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    in_valid = 1'b1;
    ciphertext = ct;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rrel_in_reset got rdy=%b busy=%b want 1/0", in_ready, busy); end
    reset = 1'b0;
    run_block(1'b0, ct, got, lat);
    total++; if (lat != 10) begin bad++; $display("FAIL rrel_latency got %0d want 10", lat); end
    total++; if (got !== decrypt(ct, rkf10, 10)) begin bad++; $display("FAIL rrel_pt got %h want %h", got, decrypt(ct, rkf10, 10)); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid14 = 1'b0;
    out_ready = 1'b1;
    ciphertext = '0;
    keys10 = '0;
    keys14 = '0;
    build_tables();
    test_reset();
    test_fips128();
    test_nr14();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_reset_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
